// File: rtl/uart_mike_rx_if.sv
// Receiver-to-consumer bundle of the UART receive front end.
// Handshake: rx_flag rises with the one-cycle rx_done pulse and holds rx_data/frame_err; the consumer pulses rx_flag_clr to release the frame, rx_flag drops the following cycle.
interface uart_mike_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_flag_clr;
  logic                  rx_start;
  logic                  rx_done;
  logic                  rx_flag;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  frame_err;
  logic                  overrun_err;
  logic [2:0]            dbg_state;

  modport master (
    input  rx_flag_clr,
    output rx_start, rx_done, rx_flag, rx_data, frame_err, overrun_err, dbg_state
  );

  modport slave (
    output rx_flag_clr,
    input  rx_start, rx_done, rx_flag, rx_data, frame_err, overrun_err, dbg_state
  );
endinterface

// File: rtl/uart_mike_rx.sv
// UART serial receiver: synchronises rx_in, confirms the start bit at mid-bit,
// samples DATA_WIDTH bits LSB-first, checks the stop bit and holds the frame until acknowledged.
module uart_mike_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            rx_in,
  uart_mike_rx_if.master  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_MID      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1, r_sync2, r_sync_prev;
  logic [CW-1:0]         r_cyc;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_start, r_done, r_flag, r_ferr, r_ovr;
  logic                  w_rx_sync, w_fall, w_mid, w_bit_end, w_clr;
  logic                  w_confirm, w_sample, w_frame_end;

  assign w_rx_sync = r_sync2;
  // Arming on a falling edge makes a return to IDLE with the line low wait for it to go high first.
  assign w_fall    = r_sync_prev & ~r_sync2;
  assign w_mid     = (r_cyc == C_MID);
  assign w_bit_end = (r_cyc == C_BIT_END);
  assign w_clr     = (r_state == S_HOLD) && bus.rx_flag_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rx_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_confirm   = 1'b0;
    w_sample    = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: begin
        if (w_mid) begin
          if (!w_rx_sync) begin
            w_state_nxt = S_DATA;
            w_confirm   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_sample = 1'b1;
          if (r_bit == C_LAST_BIT) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_frame_end = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:  if (bus.rx_flag_clr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_HOLD) || (r_state != w_state_nxt) || w_sample)
        r_cyc <= '0;
      else
        r_cyc <= r_cyc + 1'b1;
      if (w_confirm)     r_bit <= '0;
      else if (w_sample) r_bit <= r_bit + 1'b1;
      // Right shift: after DATA_WIDTH samples the first bit lands in bit 0.
      if (w_sample) r_shift <= {w_rx_sync, r_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_start <= w_confirm;
      r_done  <= w_frame_end;
      if (w_frame_end) begin
        r_flag <= 1'b1;
        r_data <= r_shift;
        r_ferr <= ~w_rx_sync;
      end else if (w_clr) begin
        r_flag <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_clr)                                r_ovr <= 1'b0;
      else if ((r_state == S_HOLD) && w_fall)   r_ovr <= 1'b1;
    end
  end

  assign bus.rx_start    = r_start;
  assign bus.rx_done     = r_done;
  assign bus.rx_flag     = r_flag;
  assign bus.rx_data     = r_data;
  assign bus.frame_err   = r_ferr;
  assign bus.overrun_err = r_ovr;
  assign bus.dbg_state   = r_state;
endmodule
